tx_word_scheduler: RTL
======================

# tx_word_scheduler

Round-robin scheduler that shares the 32-bit RS-232 word transmitter between two requesters (AES result path and status/control path). It captures one 32-bit word from the granted requester, launches the transmitter with a single-cycle start pulse, and waits for its completion pulse. It enforces a timeout and an inter-package idle gap before granting again. It sits directly in front of the 4-byte serial transmitter and drives its data and start inputs.

## Interface
- GAP_CYCLES, 20, idle cycles inserted after each package before the next grant (0 = none)
- TIMEOUT_CYCLES, 4000, maximum WAIT cycles before a missing completion is flagged (must be ≥ 2)
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0  in  1  requester 0 request; data0 stable while high
- data0  in  32  requester 0 word
- ack0  out  1  one-cycle pulse: data0 captured
- req1  in  1  requester 1 request
- data1  in  32  requester 1 word
- ack1  out  1  one-cycle pulse: data1 captured
- tx_data  out  32  word to transmitter, held from capture until next capture
- tx_start  out  1  one-cycle launch pulse to transmitter
- tx_done  in  1  one-cycle pulse from transmitter: 4th byte finished
- busy  out  1  high whenever state ≠ IDLE
- grant_id  out  1  index of most recently granted requester
- timeout_err  out  1  sticky: a package timed out
- clr_err  in  1  synchronous clear of timeout_err

## Operation
- States: IDLE, WAIT, GAP. All outputs registered.
- IDLE: if req0|req1 sampled high at a rising edge → capture winner's data into tx_data, pulse ackN and tx_start, set grant_id, clear timer, go WAIT.
- Arbitration: one request → grant it. Both → grant the one ≠ last grant. Internal last-grant register resets to 1, so req0 wins the first tie.
- Requester handshake: hold reqN and dataN stable until ackN. reqN still high in the cycle after ackN counts as a new request. Requests in WAIT/GAP are not acknowledged; they are held pending.
- WAIT: timer increments each cycle. tx_done → go GAP. If the timer reaches TIMEOUT_CYCLES−1 with no tx_done → set timeout_err, go GAP.
- GAP: counter runs GAP_CYCLES cycles, then IDLE. GAP_CYCLES=0 → WAIT exits directly to IDLE.
- tx_done outside WAIT is ignored.
- tx_done coincident with timeout terminal count → treated as done; no error.
- clr_err and timeout set in the same cycle → set wins.
- Timer and gap counter: 16 bits, no wrap (they never reach 2^16 with legal parameters).

## Timing
- Reset values: tx_data=0, tx_start=0, ack0=ack1=0, busy=0, grant_id=0, timeout_err=0, state=IDLE, last-grant=1.
- Request sampled at edge E (state IDLE) → ackN, tx_start high and tx_data valid during cycle E+1; busy high from E+1.
- tx_start is high for exactly 1 cycle per package; ack is high for exactly 1 cycle per captured word.
- tx_done sampled at edge D → GAP from D+1. IDLE reached at D+1+GAP_CYCLES; the earliest next tx_start is one cycle later.
- Timeout: the first WAIT cycle is timer 0. timeout_err rises one cycle after WAIT cycle TIMEOUT_CYCLES−1.
- rst asserted at any point (including mid-WAIT) → immediate return to reset values, no ack/start glitch. The transmitter is reset by the same rst.

## Test plan
- Reset, then hold all inputs low for 10 cycles → every output stays at its reset value, busy=0.
- req0=1, data0=0xA5A50F0F → ack0 and tx_start pulse together 1 cycle after sampling, tx_data=0xA5A50F0F, grant_id=0. Then tx_done pulse → busy drops exactly 20 cycles after GAP entry.
- req0 and req1 both held high with data0=0x11111111 and data1=0x22222222, tx_done returned 100 cycles after each start → grant order 0,1,0,1; tx_data alternates accordingly; never two acks in one cycle.
- tx_done withheld, TIMEOUT_CYCLES=4000 → timeout_err=1 after 4000 WAIT cycles, then GAP, then IDLE. clr_err pulse → 0. Coincident tx_done and terminal count → timeout_err stays 0.
- Stray tx_done in IDLE/GAP, and req1 raised during WAIT → no state change, no ack1 until IDLE. ack1 arrives the cycle after IDLE is entered.
- rst pulsed 50 cycles into WAIT → outputs return to reset values asynchronously. The next request after release is granted to req0 on a tie.

Source files
------------

// File: rtl/tx_word_scheduler.sv
// tx_word_scheduler
//
// Round-robin scheduler sharing one 32-bit word transmitter between two
// requesters. A granted word is captured into tx_data_o, the transmitter is
// launched with a one-cycle tx_start_o pulse, and the scheduler waits for
// tx_done_i (bounded by a timeout) followed by an idle gap before the next
// grant.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   req0_i/data0_i requester 0 request and word (data stable while req high)
//   ack0_o         one-cycle pulse: data0_i captured
//   req1_i/data1_i requester 1 request and word
//   ack1_o         one-cycle pulse: data1_i captured
//   tx_data_o      word to transmitter, held until the next capture
//   tx_start_o     one-cycle launch pulse to transmitter
//   tx_done_i      one-cycle completion pulse from transmitter
//   busy_o         high whenever the scheduler is not idle
//   grant_id_o     index of the most recently granted requester
//   timeout_err_o  sticky: a package timed out
//   clr_err_i      synchronous clear of timeout_err_o

module tx_word_scheduler #(
    parameter int unsigned GAP_CYCLES     = 20,
    parameter int unsigned TIMEOUT_CYCLES = 4000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_i,
    input  logic [31:0] data0_i,
    output logic        ack0_o,
    input  logic        req1_i,
    input  logic [31:0] data1_i,
    output logic        ack1_o,
    output logic [31:0] tx_data_o,
    output logic        tx_start_o,
    input  logic        tx_done_i,
    output logic        busy_o,
    output logic        grant_id_o,
    output logic        timeout_err_o,
    input  logic        clr_err_i
);

    typedef enum logic [1:0] {StIdle, StWait, StGap} state_e;

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GapLast     = 16'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam bit          NoGap       = (GAP_CYCLES == 0);

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] gap_q, gap_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic        tx_start_q, tx_start_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        busy_q, busy_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic        err_q, err_d;
    logic        winner;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        gap_d      = gap_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        grant_d    = grant_q;
        last_d     = last_q;
        err_d      = err_q;
        winner     = 1'b0;

        // Clear first so a timeout in the same cycle overrides it.
        if (clr_err_i) begin
            err_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (req0_i || req1_i) begin
                    // On a tie, grant the requester that did not win last time.
                    winner     = (req0_i && req1_i) ? ~last_q : req1_i;
                    tx_data_d  = winner ? data1_i : data0_i;
                    ack0_d     = ~winner;
                    ack1_d     = winner;
                    tx_start_d = 1'b1;
                    grant_d    = winner;
                    last_d     = winner;
                    timer_d    = '0;
                    state_d    = StWait;
                end
            end
            StWait: begin
                // Done takes priority over the terminal count: no error then.
                if (tx_done_i || (timer_q == TimeoutLast)) begin
                    if (!tx_done_i) begin
                        err_d = 1'b1;
                    end
                    gap_d   = '0;
                    state_d = NoGap ? StIdle : StGap;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            gap_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            gap_q      <= gap_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            busy_q     <= busy_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            err_q      <= err_d;
        end
    end

    assign tx_data_o     = tx_data_q;
    assign tx_start_o    = tx_start_q;
    assign ack0_o        = ack0_q;
    assign ack1_o        = ack1_q;
    assign busy_o        = busy_q;
    assign grant_id_o    = grant_q;
    assign timeout_err_o = err_q;

endmodule
